// File: rtl/queue_arbiter_n.sv
// N-requester arbiter serving requests in arrival order through an ID queue,
// with rotating priority for simultaneous arrivals and optional hold-time preemption.
module queue_arbiter_n #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = $clog2(N + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic [CW-1:0]  queue_count
);

  localparam int             HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit             PREEMPT   = (MAX_HOLD > 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] holder_q, holder_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] q_q [N];
  logic [IDW-1:0] q_d [N];

  logic [IDW-1:0] wq [N];
  logic [N-1:0]   in_q;
  logic           pop, requeue, drop_to_idle;

  always_comb begin
    int unsigned    wc, nc, first;
    logic [IDW-1:0] id;
    state_d      = state_q;
    holder_d     = holder_q;
    last_id_d    = last_id_q;
    hold_d       = hold_q;
    pop          = 1'b0;
    requeue      = 1'b0;
    drop_to_idle = 1'b0;
    in_q         = '0;
    wc           = 0;
    nc           = 0;
    first        = 0;
    id           = '0;
    for (int unsigned k = 0; k < N; k++) begin
      wq[k]  = '0;
      q_d[k] = '0;
    end

    // Withdrawn entries are squeezed out first; survivors keep relative order.
    for (int unsigned k = 0; k < N; k++) begin
      if (k < 32'(count_q)) begin
        in_q[q_q[k]] = 1'b1;
        if (req[q_q[k]]) begin
          wq[IDW'(wc)] = q_q[k];
          wc = wc + 1;
        end
      end
    end

    unique case (state_q)
      IDLE: pop = (wc != 0);
      GRANT: begin
        if (!req[holder_q]) begin
          pop          = (wc != 0);
          drop_to_idle = (wc == 0);
        end else if (PREEMPT && hold_q == HOLD_LAST) begin
          if (wc != 0) begin
            pop     = 1'b1;
            requeue = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: ;
    endcase

    first = 32'(pop);
    for (int unsigned k = 0; k < N; k++) begin
      if (k >= first && k < wc) begin
        q_d[IDW'(nc)] = wq[k];
        nc = nc + 1;
      end
    end

    // New arrivals are appended in rotating order starting just after last_id;
    // a preempted holder goes behind them.
    for (int unsigned j = 0; j < N; j++) begin
      id = IDW'((32'(last_id_q) + 1 + j) % N);
      if (req[id] && !in_q[id] && !(state_q == GRANT && holder_q == id)) begin
        q_d[IDW'(nc)] = id;
        nc = nc + 1;
      end
    end
    if (requeue) begin
      q_d[IDW'(nc)] = holder_q;
      nc = nc + 1;
    end

    if (pop) begin
      state_d   = GRANT;
      holder_d  = wq[0];
      last_id_d = wq[0];
      hold_d    = '0;
    end else if (drop_to_idle) begin
      state_d  = IDLE;
      holder_d = '0;
      hold_d   = '0;
    end

    count_d = CW'(nc);
    grant_d = '0;
    if (state_d == GRANT) grant_d[holder_d] = 1'b1;
    valid_d = (state_d == GRANT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      holder_q  <= '0;
      last_id_q <= IDW'(N - 1);
      hold_q    <= '0;
      count_q   <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      for (int unsigned k = 0; k < N; k++) q_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      holder_q  <= holder_d;
      last_id_q <= last_id_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      for (int unsigned k = 0; k < N; k++) q_q[k] <= q_d[k];
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = holder_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_queue_arbiter_n.sv
// Scoreboard bench for queue_arbiter_n (N=4, MAX_HOLD=4): stimulus pushes the expected
// grant sequence with hold lengths; a negedge monitor checks each new grant against it.
module tb_queue_arbiter_n;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [2:0] queue_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int id;
    int len;   // expected granted cycles, 0 = not checked
    bit b2b;   // expected to follow another grant with no idle cycle
  } exp_t;

  exp_t sb[$];

  queue_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .queue_count (queue_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int id, input int len, input bit b2b);
    exp_t e;
    e.id  = id;
    e.len = len;
    e.b2b = b2b;
    sb.push_back(e);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_grant"}, grant, 0);
    chk({name, "_valid"}, grant_valid, 0);
    chk({name, "_gid"}, grant_id, 0);
    chk({name, "_qc"}, queue_count, 0);
  endtask

  // Monitor: a change of grant to a nonzero value is a new grant event.
  initial begin
    logic [3:0] prev_g;
    logic [3:0] eg;
    int         cur_len;
    int         cur_exp;
    exp_t       e;
    prev_g  = '0;
    cur_len = 0;
    cur_exp = 0;
    forever begin
      @(negedge clock);
      if (grant !== prev_g) begin
        if (prev_g != 0 && cur_exp != 0) chk("hold_len", cur_len, cur_exp);
        if (grant != 0) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_grant: got grant %b expected none at %0t", grant, $time);
          end else begin
            e  = sb.pop_front();
            eg = '0;
            eg[e.id] = 1'b1;
            chk("sb_grant", grant, eg);
            chk("sb_grant_id", grant_id, e.id);
            chk("sb_valid", grant_valid, 1);
            chk("sb_back_to_back", (prev_g != 0), e.b2b);
          end
          cur_len = 1;
          cur_exp = e.len;
        end
      end else if (grant != 0) begin
        cur_len++;
      end
      prev_g = grant;
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    // Reset and single requester
    step(2);
    reset = 1'b0;
    chk_idle("reset");
    push(0, 1, 0);
    req = 4'b0001;
    step(1);
    chk("single_qc", queue_count, 1);
    chk("single_no_grant", grant, 0);
    step(1);
    chk("single_grant", grant, 4'b0001);
    chk("single_qc0", queue_count, 0);
    req = 4'b0000;
    step(1);
    chk_idle("single_release");

    // Arrival order 2,1,3 with back-to-back handover
    push(2, 3, 0);
    push(1, 3, 1);
    push(3, 3, 1);
    req = 4'b0100;
    step(2);
    chk("arr_grant2", grant, 4'b0100);
    req = 4'b0110;
    step(1);
    req = 4'b1110;
    step(1);
    chk("arr_qc2", queue_count, 2);
    req = 4'b1010;
    step(1);
    chk("arr_grant1", grant, 4'b0010);
    chk("arr_qc1", queue_count, 1);
    step(2);
    req = 4'b1000;
    step(1);
    chk("arr_grant3", grant, 4'b1000);
    step(2);
    req = 4'b0000;
    step(1);
    chk_idle("arr_end");

    // Simultaneous arrivals from reset: 0,1,2,3
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_idle("sim_reset");
    push(0, 1, 0);
    push(1, 1, 1);
    push(2, 1, 1);
    push(3, 1, 1);
    req = 4'b1111;
    step(1);
    chk("sim_qc4", queue_count, 4);
    step(1);
    chk("sim_first", grant_id, 0);
    chk("sim_qc3", queue_count, 3);
    req = 4'b1110; step(1);
    req = 4'b1100; step(1);
    req = 4'b1000; step(1);
    req = 4'b0000; step(1);
    chk_idle("sim_end");

    // Make last_id = 1, then simultaneous arrivals give 2,3,0,1
    push(1, 1, 0);
    req = 4'b0010;
    step(2);
    req = 4'b0000;
    step(1);
    push(2, 1, 0);
    push(3, 1, 1);
    push(0, 1, 1);
    push(1, 1, 1);
    req = 4'b1111;
    step(1);
    chk("rot_qc4", queue_count, 4);
    step(1);
    chk("rot_first", grant_id, 2);
    req = 4'b1011; step(1);
    req = 4'b0011; step(1);
    req = 4'b0010; step(1);
    req = 4'b0000; step(1);
    chk_idle("rot_end");

    // Preemption after MAX_HOLD cycles, then a lone holder keeps the grant
    push(0, 4, 0);
    req = 4'b0001;
    step(2);
    chk("pre_grant0", grant, 4'b0001);
    req = 4'b0011;
    step(3);
    chk("pre_still0", grant, 4'b0001);
    chk("pre_qc1", queue_count, 1);
    push(1, 2, 1);
    step(1);
    chk("pre_grant1", grant, 4'b0010);
    chk("pre_requeued", queue_count, 1);
    push(0, 11, 1);
    step(1);
    req = 4'b0001;
    step(1);
    chk("pre_regrant0", grant, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("pre_alone_hold", grant, 4'b0001);
    end
    req = 4'b0000;
    step(1);
    chk_idle("pre_end");

    // Withdrawal of a queued requester
    push(0, 3, 0);
    push(1, 1, 1);
    push(3, 1, 1);
    req = 4'b0001;
    step(2);
    req = 4'b1111;
    step(1);
    chk("wd_qc3", queue_count, 3);
    req = 4'b1011;
    step(1);
    chk("wd_qc2", queue_count, 2);
    req = 4'b1010;
    step(1);
    chk("wd_grant1", grant, 4'b0010);
    req = 4'b1000;
    step(1);
    chk("wd_grant3", grant, 4'b1000);
    req = 4'b0000;
    step(1);
    chk_idle("wd_end");

    // Reset while granting, then re-enqueue from index 0 rotation
    push(1, 2, 0);
    req = 4'b0010;
    step(2);
    req = 4'b1011;
    step(1);
    chk("mid_qc2", queue_count, 2);
    chk("mid_grant1", grant, 4'b0010);
    reset = 1'b1;
    step(1);
    chk_idle("mid_reset");
    reset = 1'b0;
    push(0, 1, 0);
    push(1, 1, 1);
    push(3, 1, 1);
    step(1);
    chk("mid_qc3", queue_count, 3);
    step(1);
    chk("mid_first", grant_id, 0);
    req = 4'b1010; step(1);
    req = 4'b1000; step(1);
    req = 4'b0000; step(1);
    chk_idle("mid_end");

    step(2);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/queue_arbiter_n.md
# queue_arbiter_n

Parametrised N-requester arbiter that serves requests in arrival order through an internal ID queue, with optional hold-time preemption. Generalises the two-requester queue arbiter: any number of requesters, simultaneous arrivals ordered by rotating priority, withdrawal of pending requests, and fair re-queueing of a holder that exceeds its hold budget. Sits between N bus masters and a single shared resource.

## Interface
- N, 4: number of requesters, legal 2..16.
- MAX_HOLD, 8: maximum consecutive grant cycles before preemption; 0 disables preemption.
- IDW, max(1,$clog2(N)) (derived, not overridden): requester ID width.
- CW, $clog2(N+1) (derived): queue count width.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  level request per requester; held high until done with the resource.
- grant  out  N  one-hot grant, registered; all-zero when idle.
- grant_valid  out  1  OR of grant, registered.
- grant_id  out  IDW  index of granted requester; 0 when idle.
- queue_count  out  CW  number of requesters waiting in queue (excludes holder).

## Operation
- Queue: N entries of IDW bits, head at slot 0. Each requester ID appears at most once in queue-plus-holder, so no overflow.
- Enqueue: at each edge, every i with req[i]=1, not queued, not holder, becomes pending and is appended.
- Simultaneous arrivals: appended in rotating order starting at (last_id+1) mod N, ascending with wrap. last_id = ID most recently granted; reset value N-1, so index 0 wins first.
- Withdrawal: queued i with req[i]=0 is removed at that edge; remaining entries keep relative order and compact toward head.
- States: IDLE (no holder), GRANT (one holder).
- IDLE: if queue non-empty at an edge, pop head → GRANT, grant that ID at the same edge. Arrivals seen at this same edge are not eligible until next edge.
- GRANT, release: holder req=0 at an edge → holder dropped. If queue (after same-edge withdrawals, before same-edge arrivals) is non-empty, pop head and grant at that edge (back-to-back, no gap); else → IDLE, grant=0.
- GRANT, preemption (MAX_HOLD>0): hold counter counts granted cycles of the current holder. When it equals MAX_HOLD-1 and holder req=1: if queue non-empty, pop head and grant it; old holder appended at tail after same-edge new arrivals. If queue empty, holder keeps grant, counter restarts at 0.
- Hold counter resets to 0 on every new grant; width $clog2(MAX_HOLD+1).
- queue_count, grant, grant_id, grant_valid are registered and mutually consistent in every cycle.

## Timing
- Reset (synchronous, overrides all): grant=0, grant_valid=0, grant_id=0, queue_count=0, queue cleared, last_id=N-1, hold counter=0, state IDLE. Reset mid-grant drops grant at that edge.
- Latency, empty arbiter: req[i] rises before edge E0 → queue_count=1 after E0 → grant[i]=1, queue_count=0 after E1.
- Handover: holder drops req before edge E → new holder granted after E; zero idle cycles.
- Max continuous hold with contention: MAX_HOLD cycles.
- Holder and grant never change other than at release, preemption or reset.
- Request that pulses high then low before it is granted is withdrawn; it never receives a grant.

## Test plan
- Reset/single: N=4; reset 2 cycles, req=0001 → queue_count=1 next cycle, grant=0001, grant_id=0 the cycle after; drop req[0] → grant=0000 next cycle.
- Arrival order: req[2] at cycle 0, req[1] cycle 2, req[3] cycle 3, all held until granted, each releases after 3 grant cycles → grant order 2,1,3, back-to-back, no idle cycle between grants.
- Simultaneous: from reset, req=1111 in one cycle → grant order 0,1,2,3; repeat with last_id=1 → order 2,3,0,1.
- Preemption: MAX_HOLD=4, req[0] held forever, req[1] raised while 0 granted → 0 held exactly 4 cycles, then 1 granted, 0 re-queued (queue_count=1); with only req[0] active, grant stays 0001 indefinitely.
- Withdrawal: holder 0, queue=[1,2,3], drop req[2] → queue_count 3→2; on release order 1 then 3; 2 never granted.
- Reset mid-operation: holder 1, queue_count=2, assert reset one cycle → all outputs 0 next cycle; requests still high re-enqueue from index 0 rotation.
